// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul engine.
// Define MATMUL_SATURATE_EN to clamp C lanes to OUT_WIDTH instead of wrapping.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    // Wide enough that a full MAX_DIM-term dot product of extreme values cannot overflow.
    function automatic int acc_width(input int data_width, input int dim_width);
        return 2 * data_width + dim_width;
    endfunction

    // Result is sign-correct in its low out_width bits; callers keep only those.
    function automatic logic signed [63:0] format_acc(input logic signed [63:0] acc,
                                                      input int out_width);
`ifdef MATMUL_SATURATE_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_width - 1));
        if (acc > hi) return hi;
        if (acc < lo) return lo;
        return acc;
`else
        return (acc <<< (64 - out_width)) >>> (64 - out_width);
`endif
    endfunction

endpackage

// File: rtl/matmul_mac_lane.sv
// One multiply-accumulate lane: computes a single C[i][j] over the k beats of a row.
module mac_lane
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 35,
    parameter int OUT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         enable,
    input  logic                         first,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [OUT_WIDTH-1:0]  c
);

    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [2*DATA_WIDTH-1:0] product;

    assign product = a * b;

    // The first tagged beat of a row overwrites, so no explicit clear is needed between rows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= first ? ACC_WIDTH'(product) : acc + ACC_WIDTH'(product);
        end
    end

    assign c = OUT_WIDTH'(format_acc(64'(acc), OUT_WIDTH));

endmodule

// File: rtl/matmul_engine.sv
// Row-at-a-time signed matrix multiplier, C = A * B, with MAX_DIM parallel MAC lanes.
// Output formatting follows MATMUL_SATURATE_EN (see matmul_pkg).
module matmul_engine
    import matmul_pkg::*;
#(
    parameter int MAX_DIM    = 8,
    parameter int DIM_WIDTH  = $clog2(MAX_DIM),
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 32,
    parameter int RD_LAT     = 1
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic [DIM_WIDTH-1:0]                 m_dim,
    input  logic [DIM_WIDTH-1:0]                 k_dim,
    input  logic [DIM_WIDTH-1:0]                 n_dim,
    output logic                                 busy,
    output logic                                 done,
    output logic [ADDR_WIDTH-1:0]                a_addr,
    input  logic signed [DATA_WIDTH-1:0]         a_data,
    output logic [ADDR_WIDTH-1:0]                b_addr,
    input  logic [MAX_DIM-1:0][DATA_WIDTH-1:0]   b_data,
    output logic                                 c_valid,
    input  logic                                 c_ready,
    output logic [ADDR_WIDTH-1:0]                c_addr,
    output logic [MAX_DIM-1:0]                   c_mask,
    output logic [MAX_DIM-1:0][OUT_WIDTH-1:0]    c_data
);

    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, DIM_WIDTH);
    localparam int LAT_WIDTH = $clog2(RD_LAT + 1);

    state_t                           state;
    state_t                           state_next;
    logic [DIM_WIDTH-1:0]             m_reg;
    logic [DIM_WIDTH-1:0]             k_reg;
    logic [DIM_WIDTH-1:0]             row_idx;
    logic [DIM_WIDTH-1:0]             k_idx;
    logic [LAT_WIDTH-1:0]             drain_cnt;
    logic [RD_LAT-1:0]                rd_vld;
    logic [RD_LAT-1:0]                rd_first;
    logic [MAX_DIM-1:0][OUT_WIDTH-1:0] lane_out;
    logic                             accept_start;
    logic                             issue_last;
    logic                             last_row;

    assign accept_start = (state == IDLE) && start;
    assign issue_last   = (k_idx == k_reg);
    assign last_row     = (row_idx == m_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ISSUE;
            ISSUE:   if (issue_last) state_next = DRAIN;
            DRAIN:   if (drain_cnt == LAT_WIDTH'(RD_LAT)) state_next = WRITE;
            WRITE:   if (c_ready) state_next = last_row ? DONE : ISSUE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign c_valid = (state == WRITE);

    // Sizes and the lane mask are latched at start so the caller may change the inputs freely.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_reg     <= '0;
            k_reg     <= '0;
            row_idx   <= '0;
            k_idx     <= '0;
            drain_cnt <= '0;
            c_mask    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg   <= m_dim;
                        k_reg   <= k_dim;
                        row_idx <= '0;
                        k_idx   <= '0;
                        for (int j = 0; j < MAX_DIM; j++) begin
                            c_mask[j] <= (j <= int'(n_dim));
                        end
                    end
                end
                ISSUE: begin
                    if (!issue_last) k_idx <= k_idx + 1'b1;
                    drain_cnt <= '0;
                end
                DRAIN: drain_cnt <= drain_cnt + 1'b1;
                WRITE: begin
                    if (c_ready && !last_row) begin
                        row_idx <= row_idx + 1'b1;
                        k_idx   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tags travel alongside the memory read so each lane knows when a*b is valid and which beat is first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld   <= '0;
            rd_first <= '0;
        end else begin
            rd_vld[0]   <= (state == ISSUE);
            rd_first[0] <= (state == ISSUE) && (k_idx == '0);
            for (int s = 1; s < RD_LAT; s++) begin
                rd_vld[s]   <= rd_vld[s-1];
                rd_first[s] <= rd_first[s-1];
            end
        end
    end

    assign a_addr = ADDR_WIDTH'({row_idx, k_idx});
    assign b_addr = ADDR_WIDTH'(k_idx);
    assign c_addr = ADDR_WIDTH'(row_idx);

    for (genvar j = 0; j < MAX_DIM; j++) begin : g_lane
        mac_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .OUT_WIDTH (OUT_WIDTH)
        ) u_lane (
            .clk    (clk),
            .reset_n(reset_n),
            .clear  (accept_start),
            .enable (rd_vld[RD_LAT-1]),
            .first  (rd_first[RD_LAT-1]),
            .a      (a_data),
            .b      ($signed(b_data[j])),
            .c      (lane_out[j])
        );

        assign c_data[j] = (c_valid && c_mask[j]) ? lane_out[j] : '0;
    end

endmodule

// File: tb/tb_matmul_engine.sv
// Scoreboard bench for matmul_engine: a reference model pushes expected rows at start,
// the monitor pops and compares each accepted row. Honours MATMUL_SATURATE_EN.
module tb_matmul_engine;

    localparam int MAX_DIM    = 8;
    localparam int DIM_WIDTH  = 3;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 16;
    localparam int OUT_WIDTH  = 16;
    localparam int RD_LAT     = 3;
    localparam int LIMIT      = 500;

    typedef struct {
        logic [31:0]  addr;
        logic [7:0]   mask;
        logic [127:0] data;
    } row_t;

    logic                                clk = 1'b0;
    logic                                reset_n;
    logic                                start;
    logic [DIM_WIDTH-1:0]                m_dim, k_dim, n_dim;
    logic                                busy, done;
    logic [ADDR_WIDTH-1:0]               a_addr, b_addr, c_addr;
    logic signed [DATA_WIDTH-1:0]        a_data;
    logic [MAX_DIM-1:0][DATA_WIDTH-1:0]  b_data;
    logic                                c_valid, c_ready;
    logic [MAX_DIM-1:0]                  c_mask;
    logic [MAX_DIM-1:0][OUT_WIDTH-1:0]   c_data;

    logic signed [15:0] a_mem [64];
    logic signed [15:0] b_mem [8][8];
    logic signed [15:0] a_pipe [RD_LAT];
    logic [7:0][15:0]   b_pipe [RD_LAT];

    row_t sb[$];
    row_t mon_row;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   exp_period = 0;
    int   last_accept = 0;
    bit   first_row = 1'b1;

    matmul_engine #(
        .MAX_DIM   (MAX_DIM),
        .DIM_WIDTH (DIM_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .m_dim  (m_dim),
        .k_dim  (k_dim),
        .n_dim  (n_dim),
        .busy   (busy),
        .done   (done),
        .a_addr (a_addr),
        .a_data (a_data),
        .b_addr (b_addr),
        .b_data (b_data),
        .c_valid(c_valid),
        .c_ready(c_ready),
        .c_addr (c_addr),
        .c_mask (c_mask),
        .c_data (c_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model with RD_LAT cycles of read latency.
    always @(posedge clk) begin
        a_pipe[0] <= a_mem[a_addr[5:0]];
        for (int j = 0; j < 8; j++) b_pipe[0][j] <= b_mem[b_addr[2:0]][j];
        for (int s = 1; s < RD_LAT; s++) begin
            a_pipe[s] <= a_pipe[s-1];
            b_pipe[s] <= b_pipe[s-1];
        end
    end
    assign a_data = a_pipe[RD_LAT-1];
    assign b_data = b_pipe[RD_LAT-1];

    task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] fmt(input longint acc);
`ifdef MATMUL_SATURATE_EN
        if (acc > 32767)  return 16'h7FFF;
        if (acc < -32768) return 16'h8000;
`endif
        return acc[15:0];
    endfunction

    task automatic push_expected(input int md, input int kd, input int nd);
        for (int i = 0; i <= md; i++) begin
            row_t r;
            r.addr = i;
            r.mask = '0;
            r.data = '0;
            for (int j = 0; j <= nd; j++) begin
                longint acc = 0;
                for (int k = 0; k <= kd; k++)
                    acc += longint'(a_mem[i*8+k]) * longint'(b_mem[k][j]);
                r.mask[j] = 1'b1;
                r.data[j*16 +: 16] = fmt(acc);
            end
            sb.push_back(r);
        end
    endtask

    task automatic clear_mem();
        for (int x = 0; x < 64; x++) a_mem[x] = '0;
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 8; j++) b_mem[k][j] = '0;
    endtask

    task automatic load_small();
        clear_mem();
        a_mem[0] = 1;  a_mem[1] = 2;  a_mem[2] = 3;
        a_mem[8] = 4;  a_mem[9] = 5;  a_mem[10] = 6;
        b_mem[0][0] = 7;  b_mem[0][1] = 8;
        b_mem[1][0] = 9;  b_mem[1][1] = 10;
        b_mem[2][0] = 11; b_mem[2][1] = 12;
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (reset_n && c_valid && c_ready) begin
            if (sb.size() == 0) begin
                check_output("unexpected_row", c_addr, 32'hFFFF_FFFF);
            end else begin
                mon_row = sb.pop_front();
                check_output("c_addr", c_addr, mon_row.addr);
                check_output("c_mask", c_mask, mon_row.mask);
                check_output("c_data", c_data, mon_row.data);
                if (exp_period != 0 && !first_row)
                    check_output("row_period", cyc - last_accept, exp_period);
                first_row   = 1'b0;
                last_accept = cyc;
            end
        end
    end

    task automatic apply_stimulus(input int md, input int kd, input int nd, input int stall);
        int n;
        int d0;
        logic [127:0] snap_data;
        logic [7:0]   snap_mask;
        logic [31:0]  snap_addr;
        push_expected(md, kd, nd);
        first_row  = 1'b1;
        exp_period = (stall == 0) ? (kd + 1 + RD_LAT + 2) : 0;
        d0 = done_cnt;
        c_ready = (stall == 0);
        m_dim = DIM_WIDTH'(md);
        k_dim = DIM_WIDTH'(kd);
        n_dim = DIM_WIDTH'(nd);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        n = 0;
        while (!c_valid && n < LIMIT) begin
            @(posedge clk); #2;
            n++;
        end
        // Edges after the start-sampling edge; counting that edge too gives K+RD_LAT+2.
        check_output("first_valid_latency", n, kd + 1 + RD_LAT + 1);
        if (stall > 0) begin
            snap_data = c_data;
            snap_mask = c_mask;
            snap_addr = c_addr;
            start = 1'b1;
            m_dim = 3'd7;
            n_dim = 3'd7;
            repeat (stall) @(posedge clk);
            #2;
            start = 1'b0;
            check_output("stall_c_valid", c_valid, 1'b1);
            check_output("stall_c_data", c_data, snap_data);
            check_output("stall_c_mask", c_mask, snap_mask);
            check_output("stall_c_addr", c_addr, snap_addr);
            check_output("stall_a_addr", a_addr, kd);
            c_ready = 1'b1;
        end
        n = 0;
        while (!done && n < LIMIT) begin
            @(posedge clk); #2;
            n++;
        end
        check_output("done_seen", done, 1'b1);
        check_output("busy_in_done", busy, 1'b1);
        @(posedge clk); #2;
        check_output("done_dropped", done, 1'b0);
        check_output("busy_dropped", busy, 1'b0);
        check_output("done_pulses", done_cnt - d0, 1);
        check_output("scoreboard_empty", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        c_ready = 1'b0;
        m_dim = '0; k_dim = '0; n_dim = '0;
        clear_mem();
        repeat (3) @(posedge clk);
        #2;
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_c_valid", c_valid, 1'b0);
        check_output("rst_a_addr", a_addr, 0);
        check_output("rst_b_addr", b_addr, 0);
        check_output("rst_c_addr", c_addr, 0);
        check_output("rst_c_mask", c_mask, 0);
        check_output("rst_c_data", c_data, 0);
        reset_n = 1'b1;
        @(posedge clk); #2;

        $display("[TB] 2x3 * 3x2");
        load_small();
        apply_stimulus(1, 2, 1, 0);

        $display("[TB] 1x1 product");
        clear_mem();
        a_mem[0] = -16'sd3;
        b_mem[0][0] = 16'sd5;
        apply_stimulus(0, 0, 0, 0);

        $display("[TB] 8x8 identity times B");
        clear_mem();
        for (int i = 0; i < 8; i++) a_mem[i*8+i] = 16'sd1;
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 8; j++) b_mem[k][j] = 16'(k*8 + j - 20);
        apply_stimulus(7, 7, 7, 0);

        $display("[TB] backpressure on row 0");
        load_small();
        apply_stimulus(1, 2, 1, 20);

        $display("[TB] output overflow");
        clear_mem();
        a_mem[0] = 16'sd32767;  a_mem[1] = 16'sd32767;
        b_mem[0][0] = 16'sd32767; b_mem[1][0] = 16'sd32767;
        b_mem[0][1] = -16'sd32768; b_mem[1][1] = -16'sd32768;
        apply_stimulus(0, 1, 1, 0);

        $display("[TB] random jobs");
        for (int x = 0; x < 64; x++) a_mem[x] = 16'($urandom_range(0, 65535));
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 8; j++) b_mem[k][j] = 16'($urandom_range(0, 65535));
        apply_stimulus(2, 4, 5, 0);
        apply_stimulus(7, 7, 7, 0);

        $display("[TB] reset mid-issue");
        load_small();
        m_dim = 3'd1; k_dim = 3'd2; n_dim = 3'd1;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_output("abort_busy", busy, 1'b0);
        check_output("abort_c_valid", c_valid, 1'b0);
        check_output("abort_a_addr", a_addr, 0);
        check_output("abort_c_mask", c_mask, 0);
        check_output("abort_c_data", c_data, 0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #2;
        check_output("abort_idle", busy, 1'b0);
        apply_stimulus(1, 2, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
